// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the only arithmetic in the serial datapath.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one operand bit per clock, LSB first, WIDTH cycles per add.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl #(
   parameter int WIDTH = serial_add_pkg::DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);
   import serial_add_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_bit;
   logic             last;

   assign last = (cnt == CW'(WIDTH - 1));
   // The carry register doubles as the carry-out once the last bit has been added.
   assign cout = carry;

   fa_cell u_fa (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (carry),
      .s  (s_bit),
      .co (c_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else if (state == DONE) begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= c_bit;
               sum   <= {s_bit, sum[WIDTH-1:1]};
               cnt   <= cnt + CW'(1);
               if (last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
                  // carry still holds the carry into the MSB on this edge
                  ovf   <= carry ^ c_bit;
`endif
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal range 2..32).
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, the operation request.
REQ-006 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-008 The block SHALL have port cin, input, 1 bit, the initial carry-in.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The block SHALL have port sum, output, WIDTH bits, the result.
REQ-012 The block SHALL have port cout, output, 1 bit, the final carry-out.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at edge k SHALL latch a, b and cin into shift/carry registers, clear the bit counter and enter RUN.
REQ-015 In RUN, each edge SHALL feed bit i of A and B plus the carry register (LSB first) through one fa_cell instance.
- That edge SHALL shift the sum bit into sum at the MSB end, update the carry register and increment the counter.
REQ-016 After the WIDTH-th RUN edge (edge k+WIDTH), the state SHALL go to DONE.
- done SHALL be 1 for exactly one cycle.
- sum and cout SHALL hold the final result.
REQ-017 From DONE with start=0, the state SHALL go to IDLE.
- sum and cout SHALL stay stable until the next accepted start.
REQ-018 busy SHALL be 1 exactly in RUN.
REQ-019 start while busy=1 SHALL be ignored: no relatch and no effect on the current operation.
REQ-020 start sampled in DONE SHALL be accepted (back-to-back operation); done still pulses for exactly that one cycle.
REQ-021 Operands SHALL be sampled only on the accepting edge; changes to a, b or cin during RUN SHALL have no effect.
REQ-022 Arithmetic SHALL be unsigned: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within an operation.
REQ-024 Throughput SHALL be one result per WIDTH+1 cycles with back-to-back starts.

Reset
REQ-025 rst_n=0 SHALL, asynchronously, force the following values, including mid-RUN (the operation is discarded):
- state IDLE;
- busy=0, done=0;
- sum=0, cout=0;
- carry register, counter and operand registers = 0.
REQ-026 The first accepting edge after rst_n deasserts SHALL behave as REQ-014.

Configuration
REQ-027 With macro SERIAL_ADD_OVF_EN defined, the block SHALL add output port ovf, 1 bit.
- ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB (signed two's-complement overflow).
- ovf SHALL be valid from DONE until the next accepted start, and SHALL reset to 0.
REQ-028 Without SERIAL_ADD_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 The shared package/header serial_add_pkg SHALL hold:
- state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
- the default WIDTH constant.
REQ-030 The single sub-module SHALL be fa_cell: a combinational 1-bit full adder (inputs x, y, ci; outputs s, co), instantiated exactly once.
REQ-031 No other sub-modules SHALL be used; the FSM, counter and shift registers SHALL be in serial_add_ctrl.

Verification
REQ-032 The bench SHALL cover the following scenarios at WIDTH=8:
- Basic add: a=0x5A, b=0x33, cin=0 -> done after edge k+8; sum=0x8D, cout=0; busy high for 8 cycles.
- Carry out: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with OVF_EN, ovf=0.
- Signed overflow: a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0; with OVF_EN, ovf=1.
- Start ignored while busy: start with a=0x10, b=0x20, then start pulsed at RUN cycle 3 with a=0xFF -> single done; sum=0x30, cout=0.
- Reset mid-operation: rst_n=0 at RUN cycle 4 -> immediately busy=0, done=0, sum=0x00, cout=0; next start with 0x01+0x01 gives sum=0x02.
- Back-to-back: start held high through DONE with a=0x03, b=0x04 -> second operation accepted in the DONE cycle; second done exactly 9 cycles after the first; sum=0x07.
